// File: rtl/dsi_pkg.sv
// Shared DSI CRC definitions.
// Holds the reflected CRC-16 polynomial, the default seed, the packet-engine
// FSM state type, and a single reflected 8-bit CRC step. The ECC/CRC
// checkers reuse the step function.
package dsi_pkg;

  // Reflected form of x^16 + x^12 + x^5 + 1.
  localparam logic [15:0] DSI_CRC_POLY_REFL = 16'h8408;
  localparam logic [15:0] DSI_CRC_SEED      = 16'hFFFF;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StPkt  = 1'b1
  } crc_state_e;

  // One byte folded into the CRC, bit 0 first.
  function automatic logic [15:0] dsi_crc_byte(input logic [15:0] crc,
                                               input logic [7:0]  data_byte);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data_byte[i]) begin
        c = (c >> 1) ^ DSI_CRC_POLY_REFL;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/dsi_crc_fold.sv
// Combinational multi-byte CRC fold.
// Folds bytes 0..nbytes-1 of a BYTES-wide beat into crc_in, byte 0 first.
// Ports:
//   crc_in  - CRC before the beat
//   data    - beat data, byte i at data[8i+7:8i]
//   nbytes  - number of leading bytes to fold; values above BYTES fold BYTES
//   crc_out - CRC after the beat
module dsi_crc_fold
  import dsi_pkg::*;
#(
  parameter int unsigned BYTES = 8
) (
  input  logic [15:0]                  crc_in,
  input  logic [8*BYTES-1:0]           data,
  input  logic [$clog2(BYTES+1)-1:0]   nbytes,
  output logic [15:0]                  crc_out
);

  // The loop bound is BYTES, so an oversized nbytes clamps naturally.
  always_comb begin
    crc_out = crc_in;
    for (int unsigned i = 0; i < BYTES; i++) begin
      if (i < 32'(nbytes)) begin
        crc_out = dsi_crc_byte(crc_out, data[8*i +: 8]);
      end
    end
  end

endmodule

// File: rtl/dsi_crc_stream.sv
// Streaming DSI packet CRC-16 engine.
// Computes the reflected CRC-16 (seed SEED, no final XOR) over BYTES bytes per
// beat with packet framing, a partial last beat, residue check mode and
// protocol-error flagging.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   en          - beat valid
//   sop, eop    - first / last beat of packet (qualified by en)
//   nbytes      - valid byte count on the eop beat
//   check       - sampled on sop: packet carries its received CRC (check mode)
//   data        - beat bytes, byte 0 first on the wire
//   crc         - registered running CRC
//   busy        - inside a packet
//   done        - one-cycle pulse after the eop beat
//   crc_ok      - with done: residue is zero in check mode
//   err         - one-cycle protocol-error pulse
//   crc_final   - CRC captured on the eop beat
module dsi_crc_stream
  import dsi_pkg::*;
#(
  parameter int unsigned BYTES = 8,
  parameter logic [15:0] SEED  = DSI_CRC_SEED
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic                         sop,
  input  logic                         eop,
  input  logic [$clog2(BYTES+1)-1:0]   nbytes,
  input  logic                         check,
  input  logic [8*BYTES-1:0]           data,
  output logic [15:0]                  crc,
  output logic                         busy,
  output logic                         done,
  output logic                         crc_ok,
  output logic                         err,
  output logic [15:0]                  crc_final
);

  localparam int unsigned NbW = $clog2(BYTES + 1);

  crc_state_e state_q, state_d;

  logic [15:0] crc_q;
  logic [15:0] crc_final_q;
  logic        mode_q;
  logic        done_q;
  logic        crc_ok_q;
  logic        err_q;

  // Beat decode produced by the FSM output process.
  logic        fold_en;
  logic        pkt_start;
  logic        pkt_end;
  logic        proto_err;

  logic        mode_eff;
  logic [15:0] fold_base;
  logic [NbW-1:0] fold_cnt;
  logic [15:0] fold_out;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A sop inside a packet restarts it in place.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (en && sop && !eop) state_d = StPkt;
      StPkt:  if (en && eop)         state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output decode for the current beat.
  always_comb begin
    fold_en   = 1'b0;
    pkt_start = 1'b0;
    pkt_end   = 1'b0;
    proto_err = 1'b0;
    case (state_q)
      StIdle: begin
        if (en) begin
          if (sop) begin
            fold_en   = 1'b1;
            pkt_start = 1'b1;
            pkt_end   = eop;
          end else begin
            // Stray beat outside a packet is dropped.
            proto_err = 1'b1;
          end
        end
      end
      StPkt: begin
        if (en) begin
          fold_en   = 1'b1;
          pkt_start = sop;
          proto_err = sop;
          pkt_end   = eop;
        end
      end
      default: ;
    endcase
  end

  // A starting beat uses its own check bit; later beats use the latched mode.
  assign mode_eff  = pkt_start ? check : mode_q;
  assign fold_base = pkt_start ? SEED : crc_q;
  assign fold_cnt  = eop ? nbytes : NbW'(BYTES);

  dsi_crc_fold #(
    .BYTES (BYTES)
  ) u_fold (
    .crc_in  (fold_base),
    .data    (data),
    .nbytes  (fold_cnt),
    .crc_out (fold_out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc_q       <= SEED;
      crc_final_q <= SEED;
      mode_q      <= 1'b0;
      done_q      <= 1'b0;
      crc_ok_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if (fold_en)   crc_q       <= fold_out;
      if (pkt_start) mode_q      <= check;
      if (pkt_end)   crc_final_q <= fold_out;
      done_q   <= pkt_end;
      crc_ok_q <= pkt_end && mode_eff && (fold_out == 16'h0000);
      err_q    <= proto_err;
    end
  end

  assign crc       = crc_q;
  assign crc_final = crc_final_q;
  assign busy      = (state_q == StPkt);
  assign done      = done_q;
  assign crc_ok    = crc_ok_q;
  assign err       = err_q;

endmodule

// File: tb/tb_dsi_crc_stream.sv
// Self-checking bench for dsi_crc_stream: fixed vectors, check mode, straddled
// received CRC, protocol errors, reset abort, randomized packets, and the
// BYTES=4 / BYTES=1 builds.
module tb_dsi_crc_stream;

  typedef logic [7:0] byte_q_t[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  int n_checks = 0;
  int n_errors = 0;

  // BYTES=8 instance
  logic        en, sop, eop, check;
  logic [3:0]  nbytes;
  logic [63:0] data;
  logic [15:0] crc, crc_final;
  logic        busy, done, crc_ok, err;

  // BYTES=4 instance
  logic        en4, sop4, eop4, check4;
  logic [2:0]  nb4;
  logic [31:0] data4;
  logic [15:0] crc4, fin4;
  logic        busy4, done4, ok4, err4;

  // BYTES=1 instance
  logic        en1, sop1, eop1, check1;
  logic [0:0]  nb1;
  logic [7:0]  data1;
  logic [15:0] crc1, fin1;
  logic        busy1, done1, ok1, err1;

  dsi_crc_stream #(.BYTES(8)) dut (
    .clk(clk), .reset(reset), .en(en), .sop(sop), .eop(eop), .nbytes(nbytes),
    .check(check), .data(data), .crc(crc), .busy(busy), .done(done),
    .crc_ok(crc_ok), .err(err), .crc_final(crc_final)
  );

  dsi_crc_stream #(.BYTES(4)) dut4 (
    .clk(clk), .reset(reset), .en(en4), .sop(sop4), .eop(eop4), .nbytes(nb4),
    .check(check4), .data(data4), .crc(crc4), .busy(busy4), .done(done4),
    .crc_ok(ok4), .err(err4), .crc_final(fin4)
  );

  dsi_crc_stream #(.BYTES(1)) dut1 (
    .clk(clk), .reset(reset), .en(en1), .sop(sop1), .eop(eop1), .nbytes(nb1),
    .check(check1), .data(data1), .crc(crc1), .busy(busy1), .done(done1),
    .crc_ok(ok1), .err(err1), .crc_final(fin1)
  );

  // Monitor: records every done pulse and counts err pulses.
  logic [15:0] got_final[$];
  logic        got_ok[$];
  int          err_seen;

  always @(negedge clk) begin
    if (!reset) begin
      if (done) begin
        got_final.push_back(crc_final);
        got_ok.push_back(crc_ok);
      end
      if (err) err_seen++;
    end
  end

  // Reference CRC: the message as a bit stream, LSB of byte 0 first, shifted
  // through the reflected CRC-16 register.
  function automatic logic [15:0] ref_crc(input byte_q_t msg);
    logic [15:0] c;
    bit fb;
    c = 16'hFFFF;
    foreach (msg[k]) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ msg[k][b];
        c  = c >> 1;
        if (fb) c = c ^ 16'h8408;
      end
    end
    return c;
  endfunction

  function automatic byte_q_t from_words(input logic [63:0] a, input logic [63:0] b,
                                         input logic [63:0] c);
    byte_q_t q;
    logic [63:0] ws[3];
    ws[0] = a; ws[1] = b; ws[2] = c;
    for (int w = 0; w < 3; w++) begin
      for (int j = 0; j < 8; j++) q.push_back(ws[w][63-8*j -: 8]);
    end
    return q;
  endfunction

  function automatic byte_q_t pkt1();
    return from_words(64'hFF0000001EF01EC7, 64'h4F8278C582E08C70, 64'hD23C78E9FF000001);
  endfunction

  function automatic byte_q_t pkt2();
    return from_words(64'hFF000002B9DCF372, 64'hBBD4B85AC875C27C, 64'h81F805DFFF000001);
  endfunction

  task automatic clear_mon();
    got_final.delete();
    got_ok.delete();
    err_seen = 0;
  endtask

  task automatic beat(input bit s, input bit e, input int nb, input bit c,
                      input logic [63:0] d);
    en = 1'b1; sop = s; eop = e; nbytes = 4'(nb); check = c; data = d;
    @(posedge clk); #1;
  endtask

  // Qualifier inputs carry junk while en is low; they must be ignored.
  task automatic idle(input int n);
    en = 1'b0; sop = 1'($urandom); eop = 1'($urandom); check = 1'($urandom);
    nbytes = 4'($urandom); data = {$urandom, $urandom};
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Splits msg into 8-byte beats; the eop beat carries the remainder.
  task automatic send_pkt(input byte_q_t msg, input bit chk, input bit gaps,
                          input bit clamp);
    int nbeats, nbv, idx;
    logic [63:0] w;
    nbeats = (msg.size() == 0) ? 1 : (msg.size() + 7) / 8;
    for (int b = 0; b < nbeats; b++) begin
      for (int j = 0; j < 8; j++) begin
        idx = b * 8 + j;
        w[8*j +: 8] = (idx < msg.size()) ? msg[idx] : 8'($urandom);
      end
      nbv = (b == nbeats - 1) ? msg.size() - 8 * b : 8;
      if (clamp && b == nbeats - 1 && nbv == 8) nbv = 8 + int'($urandom_range(0, 7));
      beat(b == 0, b == nbeats - 1, nbv, (b == 0) ? chk : 1'($urandom), w);
      if (gaps && b != nbeats - 1 && $urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
    end
  endtask

  task automatic send_w4(input byte_q_t msg);
    int nbeats;
    nbeats = (msg.size() + 3) / 4;
    for (int b = 0; b < nbeats; b++) begin
      for (int j = 0; j < 4; j++) data4[8*j +: 8] = msg[b*4 + j];
      en4 = 1'b1; sop4 = (b == 0); eop4 = (b == nbeats - 1); check4 = 1'b0;
      nb4 = 3'(msg.size() - 4 * b);
      @(posedge clk); #1;
    end
    en4 = 1'b0;
  endtask

  task automatic send_w1(input byte_q_t msg);
    for (int b = 0; b < msg.size(); b++) begin
      en1 = 1'b1; sop1 = (b == 0); eop1 = (b == msg.size() - 1); check1 = 1'b0;
      nb1 = 1'b1; data1 = msg[b];
      @(posedge clk); #1;
    end
    en1 = 1'b0;
  endtask

  task automatic test_reset();
    n_checks += 5;
    if (crc !== 16'hFFFF) begin n_errors++; $display("FAIL reset_crc: got %h expected ffff", crc); end
    if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b expected 0", done); end
    if (crc_ok !== 1'b0) begin n_errors++; $display("FAIL reset_crc_ok: got %b expected 0", crc_ok); end
    if (err !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b expected 0", err); end
  endtask

  // Test vectors 1 and 2 issued back-to-back.
  task automatic test_back_to_back();
    clear_mon();
    send_pkt(pkt1(), 1'b0, 1'b0, 1'b0);
    send_pkt(pkt2(), 1'b0, 1'b0, 1'b0);
    idle(3);
    n_checks++;
    if (got_final.size() != 2) begin
      n_errors++; $display("FAIL b2b_done_count: got %0d expected 2", got_final.size());
    end else begin
      n_checks += 4;
      if (got_final[0] !== 16'hE569) begin n_errors++; $display("FAIL b2b_crc1: got %h expected e569", got_final[0]); end
      if (got_final[1] !== 16'h00F0) begin n_errors++; $display("FAIL b2b_crc2: got %h expected 00f0", got_final[1]); end
      if (got_ok[0] !== 1'b0) begin n_errors++; $display("FAIL b2b_ok1: got %b expected 0", got_ok[0]); end
      if (got_ok[1] !== 1'b0) begin n_errors++; $display("FAIL b2b_ok2: got %b expected 0", got_ok[1]); end
    end
  endtask

  task automatic test_check_mode();
    byte_q_t m;
    m = pkt1();
    m.push_back(8'h69); m.push_back(8'hE5);
    clear_mon();
    send_pkt(m, 1'b1, 1'b0, 1'b0);
    idle(2);
    m[$urandom_range(0, 23)] ^= 8'(1 << $urandom_range(0, 7));
    send_pkt(m, 1'b1, 1'b1, 1'b0);
    idle(2);
    n_checks++;
    if (got_final.size() != 2) begin
      n_errors++; $display("FAIL check_done_count: got %0d expected 2", got_final.size());
    end else begin
      n_checks += 4;
      if (got_final[0] !== 16'h0000) begin n_errors++; $display("FAIL check_residue: got %h expected 0000", got_final[0]); end
      if (got_ok[0] !== 1'b1) begin n_errors++; $display("FAIL check_ok: got %b expected 1", got_ok[0]); end
      if (got_final[1] === 16'h0000) begin n_errors++; $display("FAIL check_bad_residue: got %h expected nonzero", got_final[1]); end
      if (got_ok[1] !== 1'b0) begin n_errors++; $display("FAIL check_bad_ok: got %b expected 0", got_ok[1]); end
    end
  endtask

  // Received CRC split across a beat boundary, empty packet, nbytes clamp.
  task automatic test_straddle_edges();
    byte_q_t m;
    logic [15:0] c;
    for (int i = 0; i < 15; i++) m.push_back(8'($urandom));
    c = ref_crc(m);
    m.push_back(c[7:0]); m.push_back(c[15:8]);
    clear_mon();
    send_pkt(m, 1'b1, 1'b0, 1'b0);
    m.delete();
    send_pkt(m, 1'b0, 1'b0, 1'b0);
    send_pkt(pkt1(), 1'b0, 1'b0, 1'b1);
    idle(2);
    n_checks++;
    if (got_final.size() != 3) begin
      n_errors++; $display("FAIL edge_done_count: got %0d expected 3", got_final.size());
    end else begin
      n_checks += 4;
      if (got_ok[0] !== 1'b1) begin n_errors++; $display("FAIL straddle_ok: got %b expected 1", got_ok[0]); end
      if (got_final[1] !== 16'hFFFF) begin n_errors++; $display("FAIL empty_crc: got %h expected ffff", got_final[1]); end
      if (got_ok[1] !== 1'b0) begin n_errors++; $display("FAIL empty_ok: got %b expected 0", got_ok[1]); end
      if (got_final[2] !== 16'hE569) begin n_errors++; $display("FAIL clamp_crc: got %h expected e569", got_final[2]); end
    end
  endtask

  task automatic test_hold();
    logic [15:0] c0;
    byte_q_t m;
    logic [63:0] w0, w1;
    w0 = {$urandom, $urandom}; w1 = {$urandom, $urandom};
    for (int j = 0; j < 8; j++) m.push_back(w0[8*j +: 8]);
    for (int j = 0; j < 8; j++) m.push_back(w1[8*j +: 8]);
    clear_mon();
    beat(1'b1, 1'b0, 8, 1'b0, w0);
    c0 = crc;
    idle(3);
    n_checks += 2;
    if (crc !== c0) begin n_errors++; $display("FAIL hold_crc: got %h expected %h", crc, c0); end
    if (busy !== 1'b1) begin n_errors++; $display("FAIL hold_busy: got %b expected 1", busy); end
    beat(1'b0, 1'b1, 8, 1'b0, w1);
    idle(3);
    n_checks++;
    if (got_final.size() != 1 || got_final[0] !== ref_crc(m)) begin
      n_errors++;
      $display("FAIL hold_final: got %0d dones first %h expected 1 done %h", got_final.size(),
               (got_final.size() > 0) ? got_final[0] : 16'hxxxx, ref_crc(m));
    end
    n_checks++;
    if (crc !== ref_crc(m)) begin n_errors++; $display("FAIL hold_after_done: got %h expected %h", crc, ref_crc(m)); end
  endtask

  task automatic test_errors();
    logic [15:0] c0;
    c0 = crc;
    clear_mon();
    beat(1'b0, 1'($urandom), 8, 1'b0, {$urandom, $urandom});
    idle(2);
    n_checks += 3;
    if (err_seen != 1) begin n_errors++; $display("FAIL stray_err: got %0d expected 1", err_seen); end
    if (crc !== c0) begin n_errors++; $display("FAIL stray_crc: got %h expected %h", crc, c0); end
    if (got_final.size() != 0) begin n_errors++; $display("FAIL stray_done: got %0d expected 0", got_final.size()); end
    clear_mon();
    beat(1'b1, 1'b0, 8, 1'b1, {$urandom, $urandom});
    beat(1'b0, 1'b0, 8, 1'b0, {$urandom, $urandom});
    n_checks++;
    if (busy !== 1'b1) begin n_errors++; $display("FAIL abort_busy: got %b expected 1", busy); end
    send_pkt(pkt1(), 1'b0, 1'b0, 1'b0);
    idle(3);
    n_checks += 2;
    if (err_seen != 1) begin n_errors++; $display("FAIL restart_err: got %0d expected 1", err_seen); end
    if (got_final.size() != 1 || got_final[0] !== 16'hE569) begin
      n_errors++;
      $display("FAIL restart_crc: got %0d dones first %h expected 1 done e569", got_final.size(),
               (got_final.size() > 0) ? got_final[0] : 16'hxxxx);
    end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    beat(1'b1, 1'b0, 8, 1'b1, {$urandom, $urandom});
    beat(1'b0, 1'b0, 8, 1'b1, {$urandom, $urandom});
    reset = 1'b1;
    #2;
    n_checks += 5;
    if (crc !== 16'hFFFF) begin n_errors++; $display("FAIL rst_mid_crc: got %h expected ffff", crc); end
    if (busy !== 1'b0) begin n_errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    if (done !== 1'b0) begin n_errors++; $display("FAIL rst_mid_done: got %b expected 0", done); end
    if (crc_ok !== 1'b0) begin n_errors++; $display("FAIL rst_mid_ok: got %b expected 0", crc_ok); end
    if (err !== 1'b0) begin n_errors++; $display("FAIL rst_mid_err: got %b expected 0", err); end
    idle(1);
    reset = 1'b0;
    send_pkt(pkt1(), 1'b0, 1'b0, 1'b0);
    idle(3);
    n_checks++;
    if (got_final.size() != 1 || got_final[0] !== 16'hE569 || err_seen != 0) begin
      n_errors++;
      $display("FAIL rst_next_pkt: got %0d dones first %h errs %0d expected 1 done e569 errs 0",
               got_final.size(), (got_final.size() > 0) ? got_final[0] : 16'hxxxx, err_seen);
    end
  endtask

  task automatic test_narrow();
    send_w4(pkt1());
    n_checks += 2;
    if (done4 !== 1'b1) begin n_errors++; $display("FAIL w4_done: got %b expected 1", done4); end
    if (fin4 !== 16'hE569) begin n_errors++; $display("FAIL w4_crc: got %h expected e569", fin4); end
    send_w1(pkt1());
    n_checks += 2;
    if (done1 !== 1'b1) begin n_errors++; $display("FAIL w1_done: got %b expected 1", done1); end
    if (fin1 !== 16'hE569) begin n_errors++; $display("FAIL w1_crc: got %h expected e569", fin1); end
  endtask

  task automatic test_random();
    logic [15:0] exp_final[$];
    logic        exp_ok[$];
    byte_q_t     m;
    logic [15:0] c;
    bit          chk;
    clear_mon();
    for (int p = 0; p < 30; p++) begin
      m.delete();
      for (int i = 0; i < int'($urandom_range(0, 40)); i++) m.push_back(8'($urandom));
      chk = 1'($urandom);
      if (chk) begin
        c = ref_crc(m);
        m.push_back(c[7:0]); m.push_back(c[15:8]);
        if ($urandom_range(0, 2) == 0) m[$urandom_range(0, m.size() - 1)] ^= 8'(1 << $urandom_range(0, 7));
      end
      c = ref_crc(m);
      exp_final.push_back(c);
      exp_ok.push_back(chk && (c == 16'h0000));
      send_pkt(m, chk, 1'($urandom), 1'($urandom));
      if ($urandom_range(0, 1) == 0) idle(int'($urandom_range(1, 3)));
    end
    idle(3);
    n_checks++;
    if (got_final.size() != exp_final.size()) begin
      n_errors++;
      $display("FAIL rand_done_count: got %0d expected %0d", got_final.size(), exp_final.size());
    end else begin
      foreach (exp_final[i]) begin
        n_checks++;
        if (got_final[i] !== exp_final[i] || got_ok[i] !== exp_ok[i]) begin
          n_errors++;
          $display("FAIL rand_pkt%0d: got crc %h ok %b expected crc %h ok %b", i, got_final[i],
                   got_ok[i], exp_final[i], exp_ok[i]);
        end
      end
    end
    n_checks++;
    if (err_seen != 0) begin n_errors++; $display("FAIL rand_err: got %0d expected 0", err_seen); end
  endtask

  initial begin
    reset = 1'b1;
    en = 1'b0; sop = 1'b0; eop = 1'b0; check = 1'b0; nbytes = '0; data = '0;
    en4 = 1'b0; sop4 = 1'b0; eop4 = 1'b0; check4 = 1'b0; nb4 = '0; data4 = '0;
    en1 = 1'b0; sop1 = 1'b0; eop1 = 1'b0; check1 = 1'b0; nb1 = '0; data1 = '0;
    err_seen = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    test_reset();
    test_back_to_back();
    test_check_mode();
    test_straddle_edges();
    test_hold();
    test_errors();
    test_reset_mid();
    test_narrow();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
